// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART receiver APB register map and the
// sequencer that drives it.
//   - register addresses of the UART receiver APB slave
//   - sequencer FSM state encoding
//   - APB transfer phase encoding used inside the sequencer
package uart_apb_pkg;

   // UART receiver register map
   localparam logic [2:0] ADDR_STATUS = 3'd0;  // bit 0: byte ready
   localparam logic [2:0] ADDR_ERR    = 3'd1;  // bits 1:0: error code
   localparam logic [2:0] ADDR_BP_LO  = 3'd2;  // bit period bits 7:0
   localparam logic [2:0] ADDR_BP_HI  = 3'd3;  // bit period bits 13:8
   localparam logic [2:0] ADDR_DSIZE  = 3'd4;  // data bits per frame
   localparam logic [2:0] ADDR_RXDATA = 3'd6;  // received byte

   typedef enum logic [2:0] {
      IDLE,
      CFG_LO,
      CFG_HI,
      CFG_SIZE,
      GAP,
      POLL,
      RD_ERR,
      RD_DATA
   } seq_state_t;

   // Phase within a transfer state. PH_TURN is the mandatory psel-low
   // clock between two back-to-back transfers.
   localparam logic [1:0] PH_SETUP  = 2'd0;
   localparam logic [1:0] PH_ACCESS = 2'd1;
   localparam logic [1:0] PH_TURN   = 2'd2;

endpackage

// File: rtl/uart_rx_apb_sequencer_if.sv
// Bus bundle between the sequencer, the UART receiver APB slave and the
// byte consumer.
//   APB     : psel, penable, pwrite, paddr[2:0], pwdata[7:0] (master out),
//             prdata[7:0], pslverr (master in)
//   stream  : rx_byte[7:0], rx_err[1:0], rx_valid (master out),
//             rx_ready (master in)
// Stream handshake: a word transfers on every clock where rx_valid and
// rx_ready are both high; rx_valid never depends on rx_ready, and the word
// presented stays stable until it is taken.
interface uart_rx_apb_sequencer_if;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [2:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pslverr;
   logic [7:0] rx_byte;
   logic [1:0] rx_err;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pslverr,
      output rx_byte, rx_err, rx_valid,
      input  rx_ready
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pslverr,
      input  rx_byte, rx_err, rx_valid,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_apb_sequencer_fifo.sv
// rx_stream_fifo: circular output FIFO for {err,data} words.
//   clk, n_rst : clock, asynchronous active-low reset (flushes)
//   push/wdata : write a word (ignored when full unless a pop happens too)
//   pop        : remove head (ignored when empty)
//   rdata      : head word, forced to 0 when empty
//   full/empty : status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rx_stream_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             pop_en;
   logic             push_en;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_en  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO may still accept.
   assign push_en = push && (!full || pop_en);
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/uart_rx_apb_sequencer.sv
// uart_rx_apb_sequencer: APB master that configures the UART receiver
// (bit period, data size), then polls its status and drains received bytes
// into an output FIFO presented as a valid/ready stream.
//   clk, n_rst : clock, asynchronous active-low reset
//   start      : one-cycle pulse, honoured only in IDLE
//   bus        : APB master signals and the rx_byte/rx_err stream
//   cfg_done   : set once the three configuration writes complete
//   slv_err    : sticky, set by any access phase with pslverr
//   dbg_state  : current FSM state
module uart_rx_apb_sequencer
   import uart_apb_pkg::*;
#(
   parameter logic [13:0] BIT_PERIOD = 14'd10,
   parameter logic [3:0]  DATA_SIZE  = 4'd8,
   parameter int          FIFO_DEPTH = 4,
   parameter int          POLL_GAP   = 2
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start,
   uart_rx_apb_sequencer_if.master bus,
   output logic                    cfg_done,
   output logic                    slv_err,
   output logic [2:0]              dbg_state
);
   // GAP always lasts at least one clock so psel drops between transfers.
   localparam logic [7:0] GAP_LAST = (POLL_GAP > 1) ? 8'(POLL_GAP - 1) : 8'd0;

   seq_state_t state;
   seq_state_t next_xfer;
   logic [1:0] phase;
   logic [7:0] gap_cnt;
   logic [1:0] err_q;
   logic       err_bad;

   logic       is_xfer;
   logic       psel_c;
   logic       access;
   logic [2:0] addr_c;
   logic [7:0] wdata_c;
   logic       write_c;

   logic       fifo_push;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [9:0] fifo_head;

   assign is_xfer = (state != IDLE) && (state != GAP);
   assign psel_c  = is_xfer && ((phase == PH_SETUP) || (phase == PH_ACCESS));
   assign access  = is_xfer && (phase == PH_ACCESS);

   // Address/data depend on state only, so they hold across setup and access.
   always_comb begin
      addr_c  = '0;
      wdata_c = '0;
      write_c = 1'b0;
      case (state)
         CFG_LO: begin
            addr_c  = ADDR_BP_LO;
            wdata_c = BIT_PERIOD[7:0];
            write_c = 1'b1;
         end
         CFG_HI: begin
            addr_c  = ADDR_BP_HI;
            wdata_c = {2'b00, BIT_PERIOD[13:8]};
            write_c = 1'b1;
         end
         CFG_SIZE: begin
            addr_c  = ADDR_DSIZE;
            wdata_c = {4'b0000, DATA_SIZE};
            write_c = 1'b1;
         end
         POLL:    addr_c = ADDR_STATUS;
         RD_ERR:  addr_c = ADDR_ERR;
         RD_DATA: addr_c = ADDR_RXDATA;
         default: ;
      endcase
   end

   // Successor of a transfer state reached through a turnaround clock.
   always_comb begin
      next_xfer = GAP;
      case (state)
         CFG_LO:  next_xfer = CFG_HI;
         CFG_HI:  next_xfer = CFG_SIZE;
         POLL:    next_xfer = RD_ERR;
         RD_ERR:  next_xfer = RD_DATA;
         default: next_xfer = GAP;
      endcase
   end

   // Outputs decode straight from reset registers, so they fall to 0 as soon
   // as n_rst asserts.
   assign bus.psel    = psel_c;
   assign bus.penable = access;
   assign bus.pwrite  = psel_c ? write_c : 1'b0;
   assign bus.paddr   = psel_c ? addr_c  : 3'd0;
   assign bus.pwdata  = psel_c ? wdata_c : 8'd0;
   assign dbg_state   = state;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         phase    <= PH_SETUP;
         gap_cnt  <= '0;
         err_q    <= '0;
         err_bad  <= 1'b0;
         cfg_done <= 1'b0;
         slv_err  <= 1'b0;
      end else begin
         if (access && bus.pslverr) slv_err <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= CFG_LO;
                  phase <= PH_SETUP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state   <= POLL;
                  phase   <= PH_SETUP;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: begin
               case (phase)
                  PH_SETUP: phase <= PH_ACCESS;
                  PH_ACCESS: begin
                     case (state)
                        CFG_SIZE: begin
                           state    <= GAP;
                           phase    <= PH_SETUP;
                           cfg_done <= 1'b1;
                        end
                        POLL: begin
                           // A full FIFO leaves the byte in the slave.
                           if (bus.prdata[0] && !fifo_full) begin
                              phase <= PH_TURN;
                           end else begin
                              state <= GAP;
                              phase <= PH_SETUP;
                           end
                        end
                        RD_ERR: begin
                           err_q   <= bus.prdata[1:0];
                           err_bad <= bus.pslverr;
                           phase   <= PH_TURN;
                        end
                        RD_DATA: begin
                           state <= GAP;
                           phase <= PH_SETUP;
                        end
                        default: phase <= PH_TURN;
                     endcase
                  end
                  default: begin
                     state <= next_xfer;
                     phase <= PH_SETUP;
                  end
               endcase
            end
         endcase
      end
   end

   // Either read of the pair failing discards the byte.
   assign fifo_push = (state == RD_DATA) && access && !bus.pslverr && !err_bad;
   assign fifo_pop  = bus.rx_ready && !fifo_empty;

   rx_stream_fifo #(
      .WIDTH (10),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (fifo_push),
      .wdata ({err_q, bus.prdata}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.rx_valid = !fifo_empty;
   assign bus.rx_err   = fifo_head[9:8];
   assign bus.rx_byte  = fifo_head[7:0];
endmodule
